// File: rtl/warmboot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : warmboot_ctrl
// Purpose  : Arbitrated warm-boot sequencer driving the iCE40 SB_WARMBOOT cell.
// Revision : 1.0
// ============================================================================
module warmboot_ctrl #(
    parameter int NREQ   = 2,
    parameter int SETTLE = 16,
    parameter int PULSE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_img,
    input  logic              lock,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [1:0]        state,
    output logic              boot,
    output logic              s1,
    output logic              s0
);

    localparam int c_MAX = (SETTLE > PULSE) ? SETTLE : PULSE;
    localparam int CW    = $clog2(c_MAX + 1);
    localparam logic [CW-1:0] c_SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] c_PULSE_LAST  = CW'(PULSE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_grant;
    logic            r_busy;
    logic            r_boot;
    logic            r_s1;
    logic            r_s0;

    logic [NREQ-1:0] w_win;
    logic [1:0]      w_img;
    logic            w_any;
    logic            w_held;

    // Scan from the top down so the lowest active index is written last and wins.
    always_comb begin
        w_win = '0;
        w_img = 2'b00;
        w_any = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win = NREQ'(1) << i;
                w_img = req_img[2*i +: 2];
            end
        end
    end

    assign w_held = |(req & r_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_boot  <= 1'b0;
            r_s1    <= 1'b0;
            r_s0    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!lock && w_any) begin
                        r_grant      <= w_win;
                        {r_s1, r_s0} <= w_img;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Image select stays as latched; only the grant is withdrawn.
                    if (lock || !w_held) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= ST_FIRE;
                        r_boot  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_FIRE: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        r_state <= ST_DONE;
                        r_boot  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_boot <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign state = r_state;
    assign boot  = r_boot;
    assign s1    = r_s1;
    assign s0    = r_s0;

`ifdef SYNTHESIS
    SB_WARMBOOT u_warmboot (
        .BOOT (r_boot),
        .S1   (r_s1),
        .S0   (r_s0)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_warmboot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_warmboot_ctrl
// Purpose  : Directed scoreboard bench for warmboot_ctrl (NREQ=2, SETTLE=4, PULSE=2).
// Revision : 1.0
// ============================================================================
module tb_warmboot_ctrl;

    logic       clk;
    logic       r_rst;
    logic [1:0] r_req;
    logic [3:0] r_req_img;
    logic       r_lock;
    logic [1:0] w_grant;
    logic       w_busy;
    logic [1:0] w_state;
    logic       w_boot;
    logic       w_s1;
    logic       w_s0;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] g;
        logic       bt;
        logic [1:0] img;
    } exp_t;

    exp_t sbq[$];

    warmboot_ctrl #(
        .NREQ   (2),
        .SETTLE (4),
        .PULSE  (2)
    ) dut (
        .clk     (clk),
        .rst     (r_rst),
        .req     (r_req),
        .req_img (r_req_img),
        .lock    (r_lock),
        .grant   (w_grant),
        .busy    (w_busy),
        .state   (w_state),
        .boot    (w_boot),
        .s1      (w_s1),
        .s0      (w_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expectation for the coming edge, clock it, then check at negedge.
    task automatic cyc(input string tag, input logic [1:0] st, input logic [1:0] g,
                       input logic bt, input logic [1:0] img);
        exp_t e;
        exp_t x;
        x.tag = tag; x.st = st; x.g = g; x.bt = bt; x.img = img;
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        nchk++;
        assert (w_state === e.st) else begin
            nerr++; $error("FAIL %s state observed=%0d expected=%0d", e.tag, w_state, e.st);
        end
        nchk++;
        assert (w_grant === e.g) else begin
            nerr++; $error("FAIL %s grant observed=%b expected=%b", e.tag, w_grant, e.g);
        end
        nchk++;
        assert (w_busy === (e.st != 2'd0)) else begin
            nerr++; $error("FAIL %s busy observed=%b expected=%b", e.tag, w_busy, (e.st != 2'd0));
        end
        nchk++;
        assert (w_boot === e.bt) else begin
            nerr++; $error("FAIL %s boot observed=%b expected=%b", e.tag, w_boot, e.bt);
        end
        nchk++;
        assert ({w_s1, w_s0} === e.img) else begin
            nerr++; $error("FAIL %s s1s0 observed=%b expected=%b", e.tag, {w_s1, w_s0}, e.img);
        end
    endtask

    task automatic do_reset();
        r_rst = 1'b1;
        cyc("reset", 2'd0, 2'b00, 1'b0, 2'b00);
        r_rst  = 1'b0;
        r_req  = 2'b00;
        r_lock = 1'b0;
    endtask

    initial begin
        r_rst     = 1'b1;
        r_req     = 2'b00;
        r_req_img = 4'b0000;
        r_lock    = 1'b0;
        cyc("reset0", 2'd0, 2'b00, 1'b0, 2'b00);
        cyc("reset1", 2'd0, 2'b00, 1'b0, 2'b00);
        r_rst = 1'b0;
        cyc("idle", 2'd0, 2'b00, 1'b0, 2'b00);

        // Single request, image 2'b10.
        r_req = 2'b01; r_req_img = 4'b0010;
        cyc("t1_grant", 2'd1, 2'b01, 1'b0, 2'b10);
        repeat (3) cyc("t1_arm", 2'd1, 2'b01, 1'b0, 2'b10);
        repeat (2) cyc("t1_fire", 2'd2, 2'b01, 1'b1, 2'b10);
        cyc("t1_done", 2'd3, 2'b01, 1'b0, 2'b10);
        r_req = 2'b00;
        repeat (20) cyc("t1_hold", 2'd3, 2'b01, 1'b0, 2'b10);
        do_reset();

        // Simultaneous requests: requester 0 (image 01) beats requester 1 (image 11).
        r_req = 2'b11; r_req_img = 4'b1101;
        cyc("t2_grant", 2'd1, 2'b01, 1'b0, 2'b01);
        repeat (3) cyc("t2_arm", 2'd1, 2'b01, 1'b0, 2'b01);
        repeat (2) cyc("t2_fire", 2'd2, 2'b01, 1'b1, 2'b01);
        cyc("t2_done", 2'd3, 2'b01, 1'b0, 2'b01);
        do_reset();

        // Abort when req0 drops at E2, then requester 1 (image 10) wins.
        r_req = 2'b11; r_req_img = 4'b1001;
        cyc("t3_grant", 2'd1, 2'b01, 1'b0, 2'b01);
        cyc("t3_arm", 2'd1, 2'b01, 1'b0, 2'b01);
        r_req = 2'b10;
        cyc("t3_abort", 2'd0, 2'b00, 1'b0, 2'b01);
        cyc("t3_regrant", 2'd1, 2'b10, 1'b0, 2'b10);
        repeat (3) cyc("t3_arm2", 2'd1, 2'b10, 1'b0, 2'b10);
        repeat (2) cyc("t3_fire", 2'd2, 2'b10, 1'b1, 2'b10);
        cyc("t3_done", 2'd3, 2'b10, 1'b0, 2'b10);
        do_reset();

        // Lock in IDLE, lock rising in ARM, lock rising in FIRE.
        r_lock = 1'b1; r_req = 2'b01; r_req_img = 4'b0011;
        repeat (3) cyc("t4_lockidle", 2'd0, 2'b00, 1'b0, 2'b00);
        r_lock = 1'b0;
        cyc("t4_grant", 2'd1, 2'b01, 1'b0, 2'b11);
        cyc("t4_arm", 2'd1, 2'b01, 1'b0, 2'b11);
        r_lock = 1'b1;
        cyc("t4_lockabort", 2'd0, 2'b00, 1'b0, 2'b11);
        cyc("t4_lockhold", 2'd0, 2'b00, 1'b0, 2'b11);
        r_lock = 1'b0;
        cyc("t4_regrant", 2'd1, 2'b01, 1'b0, 2'b11);
        repeat (3) cyc("t4_arm2", 2'd1, 2'b01, 1'b0, 2'b11);
        cyc("t4_fire0", 2'd2, 2'b01, 1'b1, 2'b11);
        r_lock = 1'b1; r_req = 2'b00;
        cyc("t4_fire1", 2'd2, 2'b01, 1'b1, 2'b11);
        cyc("t4_done", 2'd3, 2'b01, 1'b0, 2'b11);
        do_reset();

        // Image changes after grant are ignored.
        r_req = 2'b01; r_req_img = 4'b0001;
        cyc("t5_grant", 2'd1, 2'b01, 1'b0, 2'b01);
        r_req_img = 4'b0010;
        cyc("t5_arm", 2'd1, 2'b01, 1'b0, 2'b01);
        r_req_img = 4'b1111;
        repeat (2) cyc("t5_arm", 2'd1, 2'b01, 1'b0, 2'b01);
        r_req_img = 4'b0000;
        repeat (2) cyc("t5_fire", 2'd2, 2'b01, 1'b1, 2'b01);
        cyc("t5_done", 2'd3, 2'b01, 1'b0, 2'b01);
        do_reset();

        // Reset at the first boot-high cycle, then a clean sequence.
        r_req = 2'b01; r_req_img = 4'b0010;
        cyc("t6_grant", 2'd1, 2'b01, 1'b0, 2'b10);
        repeat (3) cyc("t6_arm", 2'd1, 2'b01, 1'b0, 2'b10);
        cyc("t6_fire", 2'd2, 2'b01, 1'b1, 2'b10);
        r_rst = 1'b1;
        cyc("t6_rst", 2'd0, 2'b00, 1'b0, 2'b00);
        r_rst = 1'b0;
        cyc("t6_regrant", 2'd1, 2'b01, 1'b0, 2'b10);
        repeat (3) cyc("t6_arm2", 2'd1, 2'b01, 1'b0, 2'b10);
        repeat (2) cyc("t6_fire2", 2'd2, 2'b01, 1'b1, 2'b10);
        cyc("t6_done", 2'd3, 2'b01, 1'b0, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
